// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared FSM state encoding and default geometry constants for the
//            serial multi-word adder (serial_add_ctrl + slice_add).
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package serial_add_pkg;

  // Default slice width and slice count; operand width is their product.
  localparam int WIDTH_DEF = 10;
  localparam int WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_add_ctrl_slice_add.sv
`default_nettype none
// ============================================================================
// Module   : slice_add
// Purpose  : WIDTH-bit ripple-carry adder built from a chain of full-adder
//            cells. Also exposes the carry into the MSB so the caller can
//            derive signed overflow.
// Ports    : x, y  - addends (WIDTH bits)
//            ci    - carry in
//            s     - sum (WIDTH bits)
//            co    - carry out of the MSB
//            c_msb - carry into the MSB (bit WIDTH-1)
// Revision : 1.0  initial release
// ============================================================================
module slice_add #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out.
  logic [WIDTH:0] c;

  assign c[0] = ci;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  endgenerate

  assign co    = c[WIDTH];
  assign c_msb = c[WIDTH-1];

endmodule : slice_add
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Serial N-bit adder/subtractor (N = WIDTH*WORDS). One WIDTH-bit
//            slice is added per cycle, least significant first, through a
//            single slice_add instance. Valid/ready handshake on both sides.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            in_valid / in_ready   - request handshake
//            a, b, cin, op_sub     - operands, carry-in (add only), mode
//            out_valid / out_ready - result handshake
//            sum, cout, ovf        - result, final carry, signed overflow
//            busy                  - high whenever the FSM is not IDLE
// Revision : 1.0  initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int              IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  state_t state, state_nxt;

  // Operands and result viewed as arrays of slices so idx selects a slice.
  logic [WORDS-1:0][WIDTH-1:0] a_r;
  logic [WORDS-1:0][WIDTH-1:0] b_r;
  logic [WORDS-1:0][WIDTH-1:0] sum_r;
  logic                        carry_r;
  logic                        mode_r;
  logic [IDXW-1:0]             idx;
  logic                        cout_r;
  logic                        ovf_r;

  logic             accept;
  logic             last_slice;
  logic [WIDTH-1:0] slice_s;
  logic             slice_co;
  logic             slice_cmsb;
  logic             slice_ci;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // A result release and a new request may share one edge.
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign last_slice = (idx == LAST);

  // ----------------------------------------------------------- datapath
  // A subtract always begins with carry 1 (two's-complement +1); the mode
  // bit re-asserts it on slice 0 so that +1 is tied to the operation type.
  assign slice_ci = carry_r | (mode_r & (idx == '0));

  slice_add #(
    .WIDTH (WIDTH)
  ) u_slice_add (
    .x     (a_r[idx]),
    .y     (b_r[idx]),
    .ci    (slice_ci),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      mode_r  <= 1'b0;
      idx     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= op_sub ? ~b : b;
      carry_r <= op_sub ? 1'b1 : cin;
      mode_r  <= op_sub;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_r[idx] <= slice_s;
      carry_r    <= slice_co;
      if (last_slice) begin
        // Flags come from the top slice only; idx holds at the last slice.
        cout_r <= slice_co;
        ovf_r  <= slice_cmsb ^ slice_co;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Directed self-checking bench for serial_add_ctrl (WIDTH=10,
//            WORDS=4, N=40) with hand-computed expected values.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int WIDTH = 10;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(
    .WIDTH (WIDTH),
    .WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid after an accept edge; returns edges counted.
  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full transaction from IDLE: present, accept, check latency and result,
  // then release with in_valid low so the FSM returns to IDLE.
  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic ci, input logic sub, input logic [N-1:0] esum,
                        input logic ecout, input logic eovf);
    int lat;
    a = av; b = bv; cin = ci; op_sub = sub; in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    wait_result(lat);
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_sum"},  64'(sum),  64'(esum));
    chk({tag, "_cout"}, 64'(cout), 64'(ecout));
    chk({tag, "_ovf"},  64'(ovf),  64'(eovf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, {62'd0, busy, out_valid}, 64'd0);
  endtask

  initial begin
    int  lat;
    logic stable;
    logic seen;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_flags",     {62'd0, cout, ovf}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_op("add_wrap",  40'hFF_FFFF_FFFF, 40'h1, 1'b0, 1'b0, 40'h0,            1'b1, 1'b0);
    run_op("add_cin",   40'h3FF,          40'h0, 1'b1, 1'b0, 40'h400,          1'b0, 1'b0);
    run_op("sub_neg",   40'h5,            40'h7, 1'b0, 1'b1, 40'hFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_pos",   40'h7,            40'h5, 1'b1, 1'b1, 40'h2,            1'b1, 1'b0);
    run_op("add_ovf",   40'h7F_FFFF_FFFF, 40'h1, 1'b0, 1'b0, 40'h80_0000_0000, 1'b0, 1'b1);
    run_op("sub_ovf",   40'h80_0000_0000, 40'h1, 1'b0, 1'b1, 40'h7F_FFFF_FFFF, 1'b1, 1'b1);
    run_op("add_small", 40'h1,            40'h2, 1'b1, 1'b0, 40'h4,            1'b0, 1'b0);

    // Stall in DONE, then release and accept a new request on the same edge.
    a = 40'h12_3456_789A; b = 40'h11_1111_1111; cin = 1'b0; op_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    chk("hold_latency", 64'(lat), 64'd4);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (sum !== 40'h23_4567_89AB || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("hold_stable", 64'(stable), 64'd1);
    chk("hold_sum",    64'(sum),    64'h23_4567_89AB);
    a = 40'h5; b = 40'h6; cin = 1'b0; op_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_run", {62'd0, busy, out_valid}, 64'd2);
    wait_result(lat);
    chk("b2b_latency", 64'(lat), 64'd4);
    chk("b2b_sum",     64'(sum), 64'hB);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in RUN with idx = 2: abandon and never present a result.
    a = 40'hAB_CDEF_0123; b = 40'h1; cin = 1'b0; op_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy",      64'(busy),      64'd0);
    chk("abort_in_ready",  64'(in_ready),  64'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_add_ctrl
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 10, giving the bit width of one adder slice.
REQ-002 SHALL have parameter WORDS, default 4, giving the slices per operand; operand width is N = WIDTH*WORDS.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 SHALL have port a  input  N  operand A.
REQ-008 SHALL have port b  input  N  operand B.
REQ-009 SHALL have port cin  input  1  carry-in; used in add mode only.
REQ-010 SHALL have port op_sub  input  1  mode select: 0 = A+B+cin, 1 = A-B.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port sum  output  N  result.
REQ-014 SHALL have port cout  output  1  final carry; in subtract mode 1 means no borrow.
REQ-015 SHALL have port ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.
REQ-016 SHALL have port busy  output  1  high when the state is not IDLE.

Function
REQ-017 SHALL compute the N-bit result serially, one WIDTH-bit slice per cycle, least significant slice first, through a single WIDTH-bit ripple-carry slice adder.
REQ-018 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-019 SHALL, in IDLE, drive in_ready=1; on accept it SHALL register a, b, op_sub and the initial carry, clear the slice index, and go to RUN.
REQ-020 SHALL, on accept in subtract mode, register ~b and set the initial carry to 1, ignoring cin.
REQ-021 SHALL, in each RUN cycle, add slice[idx] of A and B plus the carry register, write the result into sum slice idx, update the carry register, and increment idx.
REQ-022 SHALL go to DONE when idx = WORDS-1 completes; out_valid SHALL therefore rise exactly WORDS cycles after the accept edge.
REQ-023 SHALL, in DONE, hold out_valid=1 and keep sum, cout and ovf stable until out_ready=1.
REQ-024 SHALL, in DONE, drive in_ready = out_ready.
REQ-025 SHALL handle DONE with out_ready=1 as follows: with in_valid=1, capture the new operation and go to RUN (back-to-back); with in_valid=0, go to IDLE.
REQ-026 SHALL hold in_ready=0 in RUN, ignoring in_valid and all operands.
REQ-027 SHALL compute ovf from the final slice only: the carry into bit WIDTH-1 XOR the carry out.
REQ-028 SHALL give sum, cout and ovf undefined meaning while out_valid=0, but SHALL never drive them X.
REQ-029 SHALL use an idx counter of $clog2(WORDS) bits, minimum 1, with no wrap beyond WORDS-1.

Reset
REQ-030 SHALL, when rst=1 at a clk edge, force state=IDLE, idx=0, carry register=0, sum=0, cout=0, ovf=0, out_valid=0, and busy=0.
REQ-031 SHALL hold in_ready=1 from the first edge after reset deasserts.
REQ-032 SHALL abandon any operation in flight when rst is asserted during RUN or DONE, and SHALL emit no partial result.
REQ-033 SHALL give rst priority over every handshake input.

Structure
REQ-034 SHALL place the FSM state encoding (IDLE, RUN, DONE) and the default WIDTH/WORDS constants in a shared package, serial_add_pkg.
REQ-035 SHALL instantiate exactly one sub-module, slice_add: a WIDTH-bit ripple-carry adder built from full-adder cells, with ports x, y, ci, s, co and a carry-into-MSB tap for ovf.
REQ-036 SHALL keep the datapath register state as follows: operand A/B shift or index registers (N bits each), a sum register (N bits), a 1-bit carry, and a mode bit.

Verification (WIDTH=10, WORDS=4, N=40; values in hex)
REQ-037 SHALL cover add a=FFFFFFFFFF, b=1, cin=0 -> sum=0000000000, cout=1, ovf=0, out_valid exactly 4 cycles after the accept edge.
REQ-038 SHALL cover add a=3FF, b=0, cin=1 -> sum=400, cout=0 (carry crosses a slice boundary).
REQ-039 SHALL cover subtract a=5, b=7 -> sum=FFFFFFFFFE, cout=0, ovf=0; and subtract a=7, b=5 -> sum=2, cout=1.
REQ-040 SHALL cover add a=7FFFFFFFFF, b=1 -> sum=8000000000, cout=0, ovf=1.
REQ-041 SHALL cover out_ready held low for 10 cycles in DONE -> sum stable and in_ready=0; then out_ready=1 with in_valid=1 on the same edge -> new operation accepted and next out_valid 4 cycles later.
REQ-042 SHALL cover rst=1 during RUN at idx=2 -> next cycle state IDLE, out_valid=0, in_ready=1, busy=0, and no result ever presented.
